// File: rtl/video_timing_pkg.sv
// video_timing_pkg: default raster constants, colour-bar table, timing flag bundle and width helper
package video_timing_pkg;
  localparam int DEF_H_ACT  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_ACT  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;
  // {r,g,b} on/off per bar: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [2:0] BAR_RGB [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
  typedef struct packed {
    logic hs;
    logic vs;
    logic va;
    logic fs;
    logic ls;
  } vtg_flags_t;
  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/vtg_delay_line.sv
// vtg_delay_line: DEPTH-stage enabled shift register with async active-low clear (DEPTH=0 is a wire)
module vtg_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 2
)(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  generate
    if (DEPTH == 0) begin : g_pass
      assign o_q = i_d;
    end else begin : g_dly
      logic [W-1:0] r_sr [DEPTH];
      // shift one stage per enabled cycle, hold otherwise
      always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
        else if (i_en) begin
          r_sr[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
      assign o_q = r_sr[DEPTH-1];
    end
  endgenerate
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator aligned to external pixel-fetch latency; VTG_TEST_PATTERN_EN adds i_pattern_sel test patterns
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACT    = DEF_H_ACT,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACT    = DEF_V_ACT,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 8,
  parameter int PIPE_LAT = 2,
  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP,
  localparam int HW      = cw(H_TOTAL),
  localparam int VW      = cw(V_TOTAL)
)(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic [3*COLOR_W-1:0] i_pix_in,
`ifdef VTG_TEST_PATTERN_EN
  input  logic [1:0]           i_pattern_sel,
`endif
  output logic [HW-1:0]        o_x,
  output logic [VW-1:0]        o_y,
  output logic                 o_hs,
  output logic                 o_vs,
  output logic                 o_va,
  output logic [COLOR_W-1:0]   o_red,
  output logic [COLOR_W-1:0]   o_green,
  output logic [COLOR_W-1:0]   o_blue,
  output logic                 o_frame_start,
  output logic                 o_line_start
);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACT + H_FP + H_SYNC - 1);
  localparam logic [HW-1:0] H_ACTC = HW'(H_ACT);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACT + V_FP + V_SYNC - 1);
  localparam logic [VW-1:0] V_ACTC = VW'(V_ACT);
`ifdef VTG_TEST_PATTERN_EN
  localparam int PAT_W = 4;
`else
  localparam int PAT_W = 0;
`endif
  localparam int DW = $bits(vtg_flags_t) + PAT_W;

  logic [HW-1:0] r_hcnt, r_x;
  logic [VW-1:0] r_vcnt, r_y;
  vtg_flags_t w_raw, r_raw, w_flags_q;
  logic [DW-1:0] w_dly_d, w_dly_q;
  logic [3*COLOR_W-1:0] w_rgb, r_rgb;
  logic r_hs, r_vs, r_va, r_fs, r_ls;

  // raster counters: h wraps every line, v advances only on h wrap
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (i_en) begin
      r_hcnt <= (r_hcnt == H_LAST) ? '0 : r_hcnt + 1'b1;
      if (r_hcnt == H_LAST) r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1;
    end

  // raw timing flags (active-high internally) decoded from the counters
  always_comb begin
    w_raw    = '0;
    w_raw.hs = (r_hcnt >= HS_BEG) && (r_hcnt <= HS_END);
    w_raw.vs = (r_vcnt >= VS_BEG) && (r_vcnt <= VS_END);
    w_raw.va = (r_hcnt < H_ACTC) && (r_vcnt < V_ACTC);
    w_raw.fs = (r_hcnt == '0) && (r_vcnt == '0);
    w_raw.ls = (r_hcnt == '0) && (r_vcnt < V_ACTC);
  end

  // x/y and their flags register together; flags clear on reset so the reset x/y=0 is not a pixel
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_x   <= '0;
      r_y   <= '0;
      r_raw <= '0;
    end else if (i_en) begin
      r_x   <= r_hcnt;
      r_y   <= r_vcnt;
      r_raw <= w_raw;
    end

`ifdef VTG_TEST_PATTERN_EN
  localparam int BAR_W = H_ACT / 8;
  localparam int BCW   = cw(BAR_W);
  localparam logic [BCW-1:0] BCNT_LAST = BCW'(BAR_W - 1);
  logic [BCW-1:0] r_bcnt;
  logic [2:0] r_bar, w_bar_q, w_bar_rgb;
  logic w_chk_q;

  // bar counter tracks x: restarts with each line and steps every H_ACT/8 pixels
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_bcnt <= '0;
      r_bar  <= '0;
    end else if (i_en) begin
      if (r_hcnt == '0) begin
        r_bcnt <= '0;
        r_bar  <= '0;
      end else if (r_bcnt == BCNT_LAST) begin
        r_bcnt <= '0;
        r_bar  <= r_bar + 1'b1;
      end else r_bcnt <= r_bcnt + 1'b1;
    end

  assign w_dly_d   = {r_raw, r_bar, r_x[3] ^ r_y[3]};
  assign {w_flags_q, w_bar_q, w_chk_q} = w_dly_q;
  assign w_bar_rgb = BAR_RGB[w_bar_q];

  // colour source: external pixels or one of the generated patterns
  always_comb
    w_rgb = (i_pattern_sel == 2'd0) ? i_pix_in :
            (i_pattern_sel == 2'd1) ? {{COLOR_W{w_bar_rgb[2]}}, {COLOR_W{w_bar_rgb[1]}}, {COLOR_W{w_bar_rgb[0]}}} :
            (i_pattern_sel == 2'd2) ? {3*COLOR_W{1'b1}} : {3*COLOR_W{w_chk_q}};
`else
  assign w_dly_d   = r_raw;
  assign w_flags_q = w_dly_q;
  assign w_rgb     = i_pix_in;
`endif

  vtg_delay_line #(.W(DW), .DEPTH(PIPE_LAT)) u_dly (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (i_en),
    .i_d    (w_dly_d),
    .o_q    (w_dly_q)
  );

  // output register: apply sync polarity, blank colour outside active video
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_hs  <= ~HS_POL;
      r_vs  <= ~VS_POL;
      r_va  <= 1'b0;
      r_fs  <= 1'b0;
      r_ls  <= 1'b0;
      r_rgb <= '0;
    end else if (i_en) begin
      r_hs  <= w_flags_q.hs ? HS_POL : ~HS_POL;
      r_vs  <= w_flags_q.vs ? VS_POL : ~VS_POL;
      r_va  <= w_flags_q.va;
      r_fs  <= w_flags_q.fs;
      r_ls  <= w_flags_q.ls;
      r_rgb <= w_flags_q.va ? w_rgb : '0;
    end

  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_hs          = r_hs;
  assign o_vs          = r_vs;
  assign o_va          = r_va;
  assign o_frame_start = r_fs;
  assign o_line_start  = r_ls;
  assign {o_red, o_green, o_blue} = r_rgb;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: randomized-enable bench against a position-based raster model (small raster, PIPE_LAT=3)
module tb_video_timing_gen;
  localparam int HA = 64, HF = 4, HSY = 8, HB = 4;
  localparam int VA = 24, VF = 2, VSY = 2, VB = 3;
  localparam int L  = 3;
  localparam bit HP = 1'b1, VP = 1'b0;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FT = HT * VT;
  localparam int XW = $clog2(HT);
  localparam int YW = $clog2(VT);
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic clk = 1'b0, rst_n = 1'b1, en = 1'b0;
  logic [23:0] pix = '0;
  logic [1:0] psel = 2'd0, last_psel = 2'd0;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic hs, vs, va, fs, ls;
  logic [7:0] red, green, blue;
  int checks = 0, errors = 0;
  int n = 0;
  bit counting = 0;
  int t_va = 0, t_hs = 0, t_vs = 0, t_fs = 0, t_ls = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACT(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACT(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(HP), .VS_POL(VP), .COLOR_W(8), .PIPE_LAT(L)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_pix_in(pix),
`ifdef VTG_TEST_PATTERN_EN
    .i_pattern_sel(psel),
`endif
    .o_x(x), .o_y(y), .o_hs(hs), .o_vs(vs), .o_va(va),
    .o_red(red), .o_green(green), .o_blue(blue),
    .o_frame_start(fs), .o_line_start(ls)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (n=%0d)", tag, obs, exp, n);
    end
  endtask

  function automatic int hpos(input int j); return j % HT; endfunction
  function automatic int vpos(input int j); return (j / HT) % VT; endfunction
  function automatic logic [23:0] fpix(input int j); return {8'(hpos(j)), 8'(vpos(j)), 8'h5A}; endfunction

  function automatic logic [23:0] prgb(input int j, input logic [1:0] s);
    int h = hpos(j), v = vpos(j);
    if (s == 2'd0) return fpix(j);
    if (s == 2'd1) return BARS[h / (HA / 8)];
    if (s == 2'd2) return 24'hFFFFFF;
    return (((h >> 3) ^ (v >> 3)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
  endfunction

  // model: after n enabled edges, x/y show position n-1 and outputs show position n-L-2
  task automatic check_outputs();
    int j = n - L - 2;
    int h, v;
    logic [XW+YW-1:0] e_xy;
    logic [4:0] e_fl;
    logic [23:0] e_rgb;
    e_xy = (n == 0) ? '0 : {XW'(hpos(n - 1)), YW'(vpos(n - 1))};
    e_fl = {~HP, ~VP, 3'b000};
    e_rgb = '0;
    if (j >= 0) begin
      h = hpos(j);
      v = vpos(j);
      e_fl[4] = (h >= HA + HF && h < HA + HF + HSY) ? HP : ~HP;
      e_fl[3] = (v >= VA + VF && v < VA + VF + VSY) ? VP : ~VP;
      e_fl[2] = h < HA && v < VA;
      e_fl[1] = h == 0 && v == 0;
      e_fl[0] = h == 0 && v < VA;
      e_rgb = e_fl[2] ? prgb(j, last_psel) : 24'h0;
    end
    check("xy", {x, y}, e_xy);
    check("flags", {hs, vs, va, fs, ls}, e_fl);
    check("rgb", {red, green, blue}, e_rgb);
  endtask

  task automatic step(input bit e);
    en = e;
    pix = (e && n - 1 - L >= 0) ? fpix(n - 1 - L) : 24'($urandom);
    @(posedge clk);
    #1;
    if (e) begin
      n++;
      last_psel = psel;
      if (counting && n >= L + 2 && n <= L + 1 + 2 * FT) begin
        t_va += int'(va);
        t_hs += int'(hs == HP);
        t_vs += int'(vs == VP);
        t_fs += int'(fs);
        t_ls += int'(ls);
      end
    end
    check_outputs();
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    counting = 1;
    for (int k = 0; k < 3 * (2 * FT + 10) && n < L + 2 + 2 * FT; k++) step($urandom_range(7, 0) != 0);
    counting = 0;
    check("two_frames_reached", 64'(n >= L + 2 + 2 * FT), 64'd1);
    check("va_total", t_va, 2 * HA * VA);
    check("hs_total", t_hs, 2 * VT * HSY);
    check("vs_total", t_vs, 2 * VSY * HT);
    check("fs_total", t_fs, 2);
    check("ls_total", t_ls, 2 * VA);

    for (int k = 0; k < FT && hpos(n - 1) != HA / 2; k++) step(1'b1);
    check("seek_midline", 64'(hpos(n - 1)), 64'(HA / 2));
    repeat (17) step(1'b0);
    repeat (300) step(1'b1);

    for (int k = 0; k < FT && !(hpos(n - 1) == 30 && vpos(n - 1) == 10); k++) step(1'b1);
    check("seek_reset_point", {16'(hpos(n - 1)), 16'(vpos(n - 1))}, {16'd30, 16'd10});
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {x, y, hs, vs, va, fs, ls, red, green, blue},
          {{(XW + YW){1'b0}}, ~HP, ~VP, 3'b000, 24'h0});
    n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_outputs();
    for (int k = 0; k < 3 * FT && n < L + 2 + FT + 100; k++) step($urandom_range(3, 0) != 0);

`ifdef VTG_TEST_PATTERN_EN
    for (int s = 1; s < 4; s++) begin
      psel = 2'(s);
      repeat (FT) step($urandom_range(7, 0) != 0);
    end
    psel = 2'd0;
    repeat (HT) step(1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
